// File: rtl/lift_call_register.sv
// Hall/car call latch with sensor checking and a direction-aware service FSM.
// Define LIFT_CALL_DEBOUNCE_EN to debounce every button over DEBOUNCE_CYCLES samples.
module lift_call_register #(
    parameter int N_FLOORS        = 12,
    parameter int DEBOUNCE_CYCLES = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_FLOORS-1:0] up_rqst,
    input  logic [N_FLOORS-1:0] dn_rqst,
    input  logic [N_FLOORS-1:0] flr_rqst,
    input  logic [N_FLOORS-1:0] floor_sense,
    input  logic                direction,
    input  logic                motion,
    input  logic                door_open,
    output logic [N_FLOORS-1:0] up_pend,
    output logic [N_FLOORS-1:0] dn_pend,
    output logic [N_FLOORS-1:0] flr_pend,
    output logic [3:0]          target_floor,
    output logic                target_valid,
    output logic [1:0]          svc_state,
    output logic                sensor_err
);

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        SERVE_UP = 2'b01,
        SERVE_DN = 2'b10
    } state_t;

    if (N_FLOORS < 2 || N_FLOORS > 16 ||
        DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 5) begin : g_bad_cfg
        $error("lift_call_register: parameter out of range");
    end

    state_t              state;
    state_t              state_n;
    logic [N_FLOORS-1:0] up_in;
    logic [N_FLOORS-1:0] dn_in;
    logic [N_FLOORS-1:0] up_set;
    logic [N_FLOORS-1:0] dn_set;
    logic [N_FLOORS-1:0] flr_set;
    logic [N_FLOORS-1:0] up_clr;
    logic [N_FLOORS-1:0] dn_clr;
    logic [N_FLOORS-1:0] flr_clr;
    logic [N_FLOORS-1:0] any_pend;
    logic [3:0]          cur;
    logic                sense_ok;
    logic                above;
    logic                below;
    logic                here;
    logic                others;
    logic                serve;
    logic [3:0]          tgt_n;
    logic                tval_n;
    logic                found;

    // Top-floor up and bottom-floor down buttons do not exist.
    always_comb begin
        up_in               = up_rqst;
        up_in[N_FLOORS-1]   = 1'b0;
        dn_in               = dn_rqst;
        dn_in[0]            = 1'b0;
    end

`ifdef LIFT_CALL_DEBOUNCE_EN
    localparam logic [2:0] DMAX = 3'(DEBOUNCE_CYCLES);

    logic [2:0] up_cnt  [N_FLOORS];
    logic [2:0] dn_cnt  [N_FLOORS];
    logic [2:0] flr_cnt [N_FLOORS];

    function automatic logic [2:0] cnt_next(
        input logic       hit,
        input logic [2:0] c
    );
        if (!hit) return 3'd0;
        if (c == DMAX) return DMAX;
        return c + 3'd1;
    endfunction

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_FLOORS; i++) begin
            if (!reset) begin
                up_cnt[i]  <= 3'd0;
                dn_cnt[i]  <= 3'd0;
                flr_cnt[i] <= 3'd0;
            end else begin
                up_cnt[i]  <= cnt_next(up_in[i], up_cnt[i]);
                dn_cnt[i]  <= cnt_next(dn_in[i], dn_cnt[i]);
                flr_cnt[i] <= cnt_next(flr_rqst[i], flr_cnt[i]);
            end
        end
    end

    // Set fires only on the sample that brings the count up to DMAX.
    always_comb begin
        up_set  = '0;
        dn_set  = '0;
        flr_set = '0;
        for (int i = 0; i < N_FLOORS; i++) begin
            up_set[i]  = up_in[i] && (up_cnt[i] == DMAX - 3'd1);
            dn_set[i]  = dn_in[i] && (dn_cnt[i] == DMAX - 3'd1);
            flr_set[i] = flr_rqst[i] && (flr_cnt[i] == DMAX - 3'd1);
        end
    end
`else
    assign up_set  = up_in;
    assign dn_set  = dn_in;
    assign flr_set = flr_rqst;
`endif

    assign sense_ok = $onehot(floor_sense);
    assign any_pend = up_pend | dn_pend | flr_pend;
    assign here     = |(any_pend & floor_sense);
    assign others   = |(any_pend & ~floor_sense);
    assign serve    = sense_ok && door_open && !motion;

    always_comb begin
        cur   = 4'd0;
        above = 1'b0;
        below = 1'b0;
        for (int i = 0; i < N_FLOORS; i++) begin
            if (floor_sense[i]) cur = 4'(i);
        end
        for (int i = 0; i < N_FLOORS; i++) begin
            if (4'(i) > cur && any_pend[i]) above = 1'b1;
            if (4'(i) < cur && any_pend[i]) below = 1'b1;
        end
    end

    // With no other call anywhere both hall directions at this floor are done.
    always_comb begin
        flr_clr = '0;
        up_clr  = '0;
        dn_clr  = '0;
        if (serve) begin
            flr_clr = floor_sense;
            if (direction || !others) up_clr = floor_sense;
            if (!direction || !others) dn_clr = floor_sense;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            up_pend    <= '0;
            dn_pend    <= '0;
            flr_pend   <= '0;
            sensor_err <= 1'b0;
        end else begin
            up_pend    <= (up_pend | up_set) & ~up_clr;
            dn_pend    <= (dn_pend | dn_set) & ~dn_clr;
            flr_pend   <= (flr_pend | flr_set) & ~flr_clr;
            sensor_err <= sensor_err | !sense_ok;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            target_floor <= 4'd0;
            target_valid <= 1'b0;
        end else begin
            state        <= state_n;
            target_floor <= tgt_n;
            target_valid <= tval_n;
        end
    end

    always_comb begin
        state_n = state;
        if (sense_ok) begin
            case (state)
                IDLE: begin
                    if (above) state_n = SERVE_UP;
                    else if (below) state_n = SERVE_DN;
                end
                SERVE_UP: begin
                    if (!(|any_pend)) state_n = IDLE;
                    else if (!above && !here && below) state_n = SERVE_DN;
                end
                SERVE_DN: begin
                    if (!(|any_pend)) state_n = IDLE;
                    else if (!below && !here && above) state_n = SERVE_UP;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Ascending/descending scans leave the nearest match in tgt_n.
    always_comb begin
        tgt_n  = target_floor;
        tval_n = target_valid;
        found  = 1'b0;
        if (sense_ok) begin
            tval_n = (state_n != IDLE);
            case (state_n)
                SERVE_UP: begin
                    for (int i = N_FLOORS - 1; i >= 0; i--) begin
                        if (4'(i) >= cur && (up_pend[i] || flr_pend[i])) begin
                            tgt_n = 4'(i);
                            found = 1'b1;
                        end
                    end
                    if (!found) begin
                        for (int i = 0; i < N_FLOORS; i++) begin
                            if (dn_pend[i]) tgt_n = 4'(i);
                        end
                    end
                end
                SERVE_DN: begin
                    for (int i = 0; i < N_FLOORS; i++) begin
                        if (4'(i) <= cur && (dn_pend[i] || flr_pend[i])) begin
                            tgt_n = 4'(i);
                            found = 1'b1;
                        end
                    end
                    if (!found) begin
                        for (int i = N_FLOORS - 1; i >= 0; i--) begin
                            if (up_pend[i]) tgt_n = 4'(i);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign svc_state = state;

endmodule

// File: tb/tb_lift_call_register.sv
// Table-driven bench for lift_call_register with a queue scoreboard.
// Expected debounce latency follows LIFT_CALL_DEBOUNCE_EN.
module tb_lift_call_register;

`ifdef LIFT_CALL_DEBOUNCE_EN
    localparam int DB = 3;
`else
    localparam int DB = 1;
`endif

    typedef struct {
        string       name;
        logic        rst;
        logic [11:0] up, dn, flr, fs;
        logic        dir, mot, door;
        logic [11:0] e_up, e_dn, e_flr;
        logic [1:0]  e_st;
        logic [3:0]  e_tf;
        logic        e_tv, e_err;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] up_rqst, dn_rqst, flr_rqst, floor_sense;
    logic        direction, motion, door_open;
    logic [11:0] up_pend, dn_pend, flr_pend;
    logic [3:0]  target_floor;
    logic        target_valid;
    logic [1:0]  svc_state;
    logic        sensor_err;

    vec_t vecs[$];
    vec_t sb[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    lift_call_register #(
        .N_FLOORS(12),
        .DEBOUNCE_CYCLES(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .up_rqst(up_rqst),
        .dn_rqst(dn_rqst),
        .flr_rqst(flr_rqst),
        .floor_sense(floor_sense),
        .direction(direction),
        .motion(motion),
        .door_open(door_open),
        .up_pend(up_pend),
        .dn_pend(dn_pend),
        .flr_pend(flr_pend),
        .target_floor(target_floor),
        .target_valid(target_valid),
        .svc_state(svc_state),
        .sensor_err(sensor_err)
    );

    task automatic add(
        input string nm, input logic rst,
        input logic [11:0] up, input logic [11:0] dn,
        input logic [11:0] flr, input logic [11:0] fs,
        input logic dir, input logic mot, input logic door,
        input logic [11:0] eu, input logic [11:0] ed,
        input logic [11:0] ef, input logic [1:0] est,
        input logic [3:0] etf, input logic etv, input logic eerr
    );
        vec_t v;
        v.name = nm; v.rst = rst;
        v.up = up; v.dn = dn; v.flr = flr; v.fs = fs;
        v.dir = dir; v.mot = mot; v.door = door;
        v.e_up = eu; v.e_dn = ed; v.e_flr = ef;
        v.e_st = est; v.e_tf = etf; v.e_tv = etv; v.e_err = eerr;
        vecs.push_back(v);
    endtask

    task automatic chk(
        input string nm, input string fld,
        input logic [11:0] got, input logic [11:0] exp
    );
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s %s: got %h expected %h", nm, fld, got, exp);
        end
    endtask

    initial begin
        logic g;
        vec_t e;
        g = (DB == 1);

        // reset holds everything clear even with buttons pressed
        add("rst0", 0, 12'h0ff, 0, 0, 12'h001, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add("rst1", 0, 12'h0ff, 0, 0, 12'h001, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++)
            add("deb_accept", 1, 12'h008, 0, 0, 12'h001, 1, 0, 0,
                (k + 1 >= DB) ? 12'h008 : 12'h000, 0, 0,
                (k >= DB) ? 2'b01 : 2'b00,
                (k >= DB) ? 4'd3 : 4'd0, k >= DB, 0);
        add("release", 1, 0, 0, 0, 12'h001, 1, 0, 0,
            12'h008, 0, 0, 2'b01, 3, 1, 0);
        add("serve_up", 1, 0, 0, 0, 12'h008, 1, 0, 1,
            0, 0, 0, 2'b01, 3, 1, 0);
        add("to_idle", 1, 0, 0, 0, 12'h008, 1, 0, 1,
            0, 0, 0, 2'b00, 3, 0, 0);
        for (int k = 0; k < DB + 2; k++)
            add("clr_beats_set", 1, 0, 12'h008, 0, 12'h008, 0, 0, 1,
                0, 0, 0, 2'b00, 3, 0, 0);
        add("door_close", 1, 0, 0, 0, 12'h008, 0, 0, 0,
            0, 0, 0, 2'b00, 3, 0, 0);
        add("glitch0", 1, 0, 0, 12'h040, 12'h008, 0, 0, 0,
            0, 0, g ? 12'h040 : 12'h000, 2'b00, 3, 0, 0);
        add("glitch1", 1, 0, 0, 12'h040, 12'h008, 0, 0, 0,
            0, 0, g ? 12'h040 : 12'h000, g ? 2'b01 : 2'b00,
            g ? 4'd6 : 4'd3, g, 0);
        add("glitch_rel", 1, 0, 0, 0, 12'h008, 0, 0, 0,
            0, 0, g ? 12'h040 : 12'h000, g ? 2'b01 : 2'b00,
            g ? 4'd6 : 4'd3, g, 0);
        add("rst2", 0, 0, 0, 0, 12'h008, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < DB; k++)
            add("dn_calls", 1, 12'h004, 12'h020, 0, 12'h100, 0, 0, 0,
                (k == DB - 1) ? 12'h004 : 12'h000,
                (k == DB - 1) ? 12'h020 : 12'h000, 0, 0, 0, 0, 0);
        add("dn_select", 1, 0, 0, 0, 12'h100, 0, 0, 0,
            12'h004, 12'h020, 0, 2'b10, 5, 1, 0);
        add("dn_serve", 1, 0, 0, 0, 12'h020, 0, 0, 1,
            12'h004, 0, 0, 2'b10, 5, 1, 0);
        add("dn_fallback", 1, 0, 0, 0, 12'h020, 0, 0, 0,
            12'h004, 0, 0, 2'b10, 2, 1, 0);
        add("rst3", 0, 0, 0, 0, 12'h001, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < DB + 2; k++)
            add("edge_floors", 1, 12'h800, 12'h001, 0, 12'h001, 1, 0, 0,
                0, 0, 0, 0, 0, 0, 0);
        add("sense_bad", 1, 0, 0, 0, 12'h009, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        add("sense_sticky", 1, 0, 0, 0, 12'h001, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int k = 0; k < DB; k++)
            add("calls_2_6_9", 1, 0, 0, 12'h244, 12'h001, 1, 0, 0,
                0, 0, (k == DB - 1) ? 12'h244 : 12'h000, 0, 0, 0, 1);
        add("calls_select", 1, 0, 0, 0, 12'h001, 1, 0, 0,
            0, 0, 12'h244, 2'b01, 2, 1, 1);
        add("bad_sense_hold", 1, 0, 0, 0, 12'h006, 1, 0, 1,
            0, 0, 12'h244, 2'b01, 2, 1, 1);
        add("serve_f2", 1, 0, 0, 0, 12'h004, 1, 0, 1,
            0, 0, 12'h240, 2'b01, 2, 1, 1);
        add("next_f6", 1, 0, 0, 0, 12'h004, 1, 0, 0,
            0, 0, 12'h240, 2'b01, 6, 1, 1);
        add("rst_mid", 0, 0, 0, 0, 12'h004, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add("after_rst", 1, 0, 0, 0, 12'h004, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        reset = 1'b0;
        up_rqst = '0; dn_rqst = '0; flr_rqst = '0;
        floor_sense = 12'h001;
        direction = 1'b1; motion = 1'b0; door_open = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            reset       = vecs[i].rst;
            up_rqst     = vecs[i].up;
            dn_rqst     = vecs[i].dn;
            flr_rqst    = vecs[i].flr;
            floor_sense = vecs[i].fs;
            direction   = vecs[i].dir;
            motion      = vecs[i].mot;
            door_open   = vecs[i].door;
            sb.push_back(vecs[i]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            chk(e.name, "up_pend", up_pend, e.e_up);
            chk(e.name, "dn_pend", dn_pend, e.e_dn);
            chk(e.name, "flr_pend", flr_pend, e.e_flr);
            chk(e.name, "svc_state", 12'(svc_state), 12'(e.e_st));
            chk(e.name, "target_floor", 12'(target_floor), 12'(e.e_tf));
            chk(e.name, "target_valid", 12'(target_valid), 12'(e.e_tv));
            chk(e.name, "sensor_err", 12'(sensor_err), 12'(e.e_err));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
